// File: rtl/sys_defs.sv
// Shared widths and the fetch queue entry payload.
package sys_defs;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned FETCH_WIDTH = 3;
  localparam int unsigned FQ_DEPTH    = 8;
  localparam int unsigned PTR_W       = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W       = PTR_W + 1;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } FQ_ENTRY;
endpackage

// File: rtl/fetch_fifo.sv
// 8-entry circular buffer, up to 3 writes and 3 reads per cycle, count based.
module fetch_fifo
  import sys_defs::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [1:0]                n_enq,
  input  FQ_ENTRY [FETCH_WIDTH-1:0] wr_data,   // index 0 lands at tail
  input  logic [1:0]                deq_req,
  output FQ_ENTRY [FETCH_WIDTH-1:0] rd_data,   // index 0 is the head entry
  output logic [FETCH_WIDTH-1:0]    rd_valid,  // bit k set iff entry k is occupied
  output logic [CNT_W-1:0]          count
);

  FQ_ENTRY          mem_q [FQ_DEPTH];
  FQ_ENTRY          mem_d [FQ_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       n_deq;

  // Next pointers, count and storage writes; flush overrides everything.
  always_comb begin
    n_deq = (CNT_W'(deq_req) > count_q) ? 2'(count_q) : deq_req;
    if (flush) n_deq = 2'd0;
    mem_d = mem_q;
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      if (2'(k) < n_enq) mem_d[tail_q + PTR_W'(k)] = wr_data[k];
    end
    head_d  = head_q + PTR_W'(n_deq);
    tail_d  = tail_q + PTR_W'(n_enq);
    count_d = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Head-relative read ports; validity comes only from the count.
  always_comb begin
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      rd_data[k]  = mem_q[head_q + PTR_W'(k)];
      rd_valid[k] = count_q > CNT_W'(k);
    end
    count = count_q;
  end

  // Pointer and count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are meaningless without a matching count.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch PC, icache slot selection and branch redirect in front of fetch_fifo.
module fetch_queue
  import sys_defs::*;
(
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              take_branch,
  input  logic [XLEN-1:0]                   branch_target,
  input  logic [FETCH_WIDTH-1:0][31:0]      Icache_data_out,
  input  logic [FETCH_WIDTH-1:0]            Icache_valid_out,
  output logic [FETCH_WIDTH-1:0][XLEN-1:0]  proc2Icache_addr,
  output logic [1:0]                        shift,
  output logic                              hit_but_stall,
  input  logic [1:0]                        dispatch_req,
  output logic [FETCH_WIDTH-1:0][31:0]      fq_inst,
  output logic [FETCH_WIDTH-1:0][XLEN-1:0]  fq_pc,
  output logic [FETCH_WIDTH-1:0]            fq_valid
);

  logic [XLEN-1:0]           pc_q, pc_d;
  logic [1:0]                n_lead;
  logic [1:0]                n_enq;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          free;
  FQ_ENTRY [FETCH_WIDTH-1:0] wr_data;
  FQ_ENTRY [FETCH_WIDTH-1:0] rd_data;
  logic [FETCH_WIDTH-1:0]    rd_valid;

  // Count leading hits from slot 2 and take as many as the queue has room for.
  always_comb begin
    n_lead = 2'd0;
    if (Icache_valid_out[2]) begin
      n_lead = 2'd1;
      if (Icache_valid_out[1]) begin
        n_lead = 2'd2;
        if (Icache_valid_out[0]) n_lead = 2'd3;
      end
    end
    free          = CNT_W'(FQ_DEPTH) - count;
    hit_but_stall = CNT_W'(n_lead) > free;
    n_enq         = hit_but_stall ? 2'(free) : n_lead;
    if (take_branch || !reset) begin
      n_enq         = 2'd0;
      hit_but_stall = 1'b0;
    end
    shift = n_enq;
    pc_d  = take_branch ? branch_target : pc_q + (XLEN'(n_enq) << 2);
  end

  // Icache addresses, enqueue payload and head view, all slot 2 = oldest.
  always_comb begin
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      proc2Icache_addr[FETCH_WIDTH-1-k] = pc_q + XLEN'(4 * k);
      wr_data[k].inst                   = Icache_data_out[FETCH_WIDTH-1-k];
      wr_data[k].pc                     = pc_q + XLEN'(4 * k);
      fq_inst[FETCH_WIDTH-1-k]          = rd_data[k].inst;
      fq_pc[FETCH_WIDTH-1-k]            = rd_data[k].pc;
      fq_valid[FETCH_WIDTH-1-k]         = rd_valid[k];
    end
  end

  // Fetch PC register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  fetch_fifo u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (take_branch),
    .n_enq    (n_enq),
    .wr_data  (wr_data),
    .deq_req  (dispatch_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus random stimulus against a scoreboard of queued {inst, pc}.
module tb_fetch_queue;
  import sys_defs::*;

  logic                             clock = 1'b0;
  logic                             reset;
  logic                             take_branch;
  logic [XLEN-1:0]                  branch_target;
  logic [FETCH_WIDTH-1:0][31:0]     Icache_data_out;
  logic [FETCH_WIDTH-1:0]           Icache_valid_out;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] proc2Icache_addr;
  logic [1:0]                       shift;
  logic                             hit_but_stall;
  logic [1:0]                       dispatch_req;
  logic [FETCH_WIDTH-1:0][31:0]     fq_inst;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] fq_pc;
  logic [FETCH_WIDTH-1:0]           fq_valid;

  int              tests = 0;
  int              fails = 0;
  FQ_ENTRY         sb[$];
  logic [XLEN-1:0] m_pc;

  fetch_queue dut (
    .clock            (clock),
    .reset            (reset),
    .take_branch      (take_branch),
    .branch_target    (branch_target),
    .Icache_data_out  (Icache_data_out),
    .Icache_valid_out (Icache_valid_out),
    .proc2Icache_addr (proc2Icache_addr),
    .shift            (shift),
    .hit_but_stall    (hit_but_stall),
    .dispatch_req     (dispatch_req),
    .fq_inst          (fq_inst),
    .fq_pc            (fq_pc),
    .fq_valid         (fq_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_valid(input int n);
    if (n >= 3) return 3'b111;
    if (n == 2) return 3'b110;
    if (n == 1) return 3'b100;
    return 3'b000;
  endfunction

  // One cycle: drive after posedge, check at negedge, then advance the model.
  task automatic step(input logic [2:0] v, input logic [1:0] d, input logic tbr,
                      input logic [XLEN-1:0] tgt);
    int sz, fr, nl, ne, nd;
    FQ_ENTRY e;
    @(posedge clock); #1;
    Icache_valid_out = v;
    dispatch_req     = d;
    take_branch      = tbr;
    branch_target    = tgt;
    for (int s = 0; s < 3; s++) Icache_data_out[2-s] = ~(m_pc + 32'(4 * s));
    @(negedge clock);
    sz = sb.size();
    fr = 8 - sz;
    nl = v[2] ? (v[1] ? (v[0] ? 3 : 2) : 1) : 0;
    ne = tbr ? 0 : ((nl < fr) ? nl : fr);
    nd = (int'(d) < sz) ? int'(d) : sz;
    chk("shift", 96'(shift), 96'(ne));
    chk("hit_but_stall", 96'(hit_but_stall), 96'(!tbr && (nl > fr)));
    chk("icache_addr", 96'(proc2Icache_addr), {m_pc, m_pc + 32'd4, m_pc + 32'd8});
    chk("fq_valid", 96'(fq_valid), 96'(exp_valid(sz)));
    for (int i = 0; i < 3; i++) begin
      if (i < sz) begin
        chk("fq_pc", 96'(fq_pc[2-i]), 96'(sb[i].pc));
        chk("fq_inst", 96'(fq_inst[2-i]), 96'(sb[i].inst));
      end
    end
    if (tbr) begin
      sb.delete();
      m_pc = tgt;
    end else begin
      repeat (nd) void'(sb.pop_front());
      for (int i = 0; i < ne; i++) begin
        e.pc   = m_pc + 32'(4 * i);
        e.inst = ~e.pc;
        sb.push_back(e);
      end
      m_pc = m_pc + 32'(4 * ne);
    end
  endtask

  initial begin
    reset            = 1'b0;
    take_branch      = 1'b0;
    branch_target    = '0;
    Icache_valid_out = 3'b111;
    Icache_data_out  = '1;
    dispatch_req     = 2'd3;
    m_pc             = '0;

    // Held in reset with hits presented: nothing may move.
    @(posedge clock); #1;
    chk("rst_shift", 96'(shift), 96'd0);
    chk("rst_hbs", 96'(hit_but_stall), 96'd0);
    chk("rst_fq_valid", 96'(fq_valid), 96'd0);
    chk("rst_addr", 96'(proc2Icache_addr), {32'd0, 32'd4, 32'd8});
    Icache_valid_out = 3'b000;
    dispatch_req     = 2'd0;
    reset            = 1'b1;

    step(3'b111, 2'd0, 1'b0, '0);
    chk("first_shift", 96'(shift), 96'd3);
    step(3'b101, 2'd0, 1'b0, '0);
    chk("first_fq_valid", 96'(fq_valid), 96'(3'b111));
    chk("first_fq_pc", 96'(fq_pc), {32'd0, 32'd4, 32'd8});
    chk("pc_after_first", 96'(proc2Icache_addr[2]), 96'd12);
    chk("gap_shift", 96'(shift), 96'd1);
    step(3'b111, 2'd0, 1'b0, '0);
    step(3'b111, 2'd0, 1'b0, '0);
    chk("fill7_shift", 96'(shift), 96'd1);
    chk("fill7_hbs", 96'(hit_but_stall), 96'd1);
    step(3'b111, 2'd0, 1'b0, '0);
    chk("full_shift", 96'(shift), 96'd0);
    step(3'b111, 2'd3, 1'b0, '0);
    chk("full_deq_shift", 96'(shift), 96'd0);
    step(3'b111, 2'd0, 1'b0, '0);
    chk("after_deq_shift", 96'(shift), 96'd3);
    step(3'b011, 2'd1, 1'b0, '0);
    chk("no_lead_hbs", 96'(hit_but_stall), 96'd0);
    step(3'b000, 2'd2, 1'b0, '0);
    step(3'b111, 2'd3, 1'b1, 32'h2000);
    chk("br_shift", 96'(shift), 96'd0);
    chk("br_fq_valid", 96'(fq_valid), 96'(3'b111));
    step(3'b110, 2'd1, 1'b0, '0);
    chk("br_addr", 96'(proc2Icache_addr), {32'h2000, 32'h2004, 32'h2008});
    chk("br_empty", 96'(fq_valid), 96'd0);
    step(3'b111, 2'd2, 1'b0, '0);
    step(3'b111, 2'd0, 1'b0, '0);

    // Asynchronous reset between edges with six entries queued.
    @(posedge clock); #1;
    Icache_valid_out = 3'b000;
    dispatch_req     = 2'd0;
    chk("pre_arst_valid", 96'(fq_valid), 96'(3'b111));
    #1 reset = 1'b0;
    #1;
    chk("arst_fq_valid", 96'(fq_valid), 96'd0);
    chk("arst_pc", 96'(proc2Icache_addr), {32'd0, 32'd4, 32'd8});
    chk("arst_shift", 96'(shift), 96'd0);
    sb.delete();
    m_pc = '0;
    #1 reset = 1'b1;

    step(3'b111, 2'd0, 1'b0, '0);
    chk("post_arst_shift", 96'(shift), 96'd3);

    for (int n = 0; n < 80; n++) begin
      step(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0), 32'($urandom_range(0, 4095)) << 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
